// File: rtl/api_slave.sv
// SPI-style slave: synchronises sck/load/mosi into clk, assembles WORD_W-bit rx words
// and serialises tx words fetched from a non-FWFT source, with per-frame word accounting.
module api_slave #(
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned FRAME_WORDS = 23,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_rst,
    input  logic              load,
    input  logic              sck,
    input  logic              mosi,
    output logic              miso,
    output logic              rx_vld,
    output logic [WORD_W-1:0] rx_dat,
    output logic              tx_rd_en,
    input  logic [WORD_W-1:0] tx_dat,
    input  logic              tx_empty,
    output logic              frame_done,
    output logic [7:0]        word_cnt,
    output logic              short_frame,
    output logic [1:0]        state
);

    localparam int unsigned CntW = $clog2(WORD_W + 1);
    localparam logic [CntW-1:0] BitsFull = CntW'(WORD_W);
    localparam logic [7:0] WordsMax  = 8'(FRAME_WORDS);
    localparam logic [7:0] WordsLast = 8'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sck_sync, load_sync, mosi_sync;
    logic                   sck_prev, load_prev;
    logic                   sck_s, load_s, mosi_s;
    logic                   sck_rise, sck_fall, load_rise, load_fall;

    logic [WORD_W-1:0] rx_sr_q, rx_sr_d;
    logic [WORD_W-1:0] tx_sr_q, tx_sr_d;
    logic [WORD_W-1:0] rx_dat_q, rx_dat_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]        word_cnt_q, word_cnt_d;
    logic              rx_vld_q, rx_vld_d;
    logic              tx_rd_en_q, tx_rd_en_d;
    logic              tx_load_q, tx_load_d;
    logic              frame_done_q, frame_done_d;
    logic              short_q, short_d;
    logic              start_pend_q, start_pend_d;

    logic full, shift_en, word_done, enter_shift, enter_done, fetch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            load_sync <= '1;
            sck_prev  <= 1'b0;
            load_prev <= 1'b1;
        end else if (reg_rst) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            load_sync <= '1;
            sck_prev  <= 1'b0;
            load_prev <= 1'b1;
        end else begin
            sck_sync[0]  <= sck;
            mosi_sync[0] <= mosi;
            load_sync[0] <= load;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sck_sync[i]  <= sck_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
                load_sync[i] <= load_sync[i-1];
            end
            sck_prev  <= sck_sync[SYNC_STAGES-1];
            load_prev <= load_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign load_s    = load_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_prev;
    assign sck_fall  = ~sck_s & sck_prev;
    assign load_rise = load_s & ~load_prev;
    assign load_fall = ~load_s & load_prev;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (load_fall || start_pend_q) state_d = StShift;
            StShift: if (load_rise) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (reg_rst) state_d = StIdle;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    assign full        = (word_cnt_q == WordsMax);
    assign shift_en    = (state_q == StShift) && !load_rise && !full;
    assign word_done   = (state_q == StShift) && (bit_cnt_q == BitsFull);
    assign enter_shift = (state_q == StIdle) && (state_d == StShift);
    assign enter_done  = (state_q == StShift) && load_rise;
    // No fetch after the last accepted word, so miso stays idle-high for the overrun.
    assign fetch       = enter_shift ||
                         (word_done && !load_rise && (word_cnt_q < WordsLast));

    always_comb begin
        rx_sr_d      = rx_sr_q;
        tx_sr_d      = tx_sr_q;
        rx_dat_d     = rx_dat_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        short_d      = short_q;
        rx_vld_d     = 1'b0;
        tx_rd_en_d   = 1'b0;
        frame_done_d = 1'b0;
        tx_load_d    = tx_rd_en_q;
        start_pend_d = (state_q == StDone) && load_fall;

        if (enter_shift) begin
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            rx_sr_d    = '0;
        end else if (word_done) begin
            rx_vld_d   = 1'b1;
            rx_dat_d   = rx_sr_q;
            word_cnt_d = word_cnt_q + 8'd1;
            bit_cnt_d  = '0;
        end else if (shift_en && sck_rise) begin
            rx_sr_d   = {rx_sr_q[WORD_W-2:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 1'b1;
        end

        // The falling edge that trails a completed word must not eat the next word's MSB.
        if (fetch) begin
            tx_rd_en_d = ~tx_empty;
            tx_sr_d    = '1;
        end else if (tx_load_q) begin
            tx_sr_d = tx_dat;
        end else if (shift_en && sck_fall && (bit_cnt_q != '0)) begin
            tx_sr_d = {tx_sr_q[WORD_W-2:0], 1'b1};
        end

        if (enter_done) begin
            frame_done_d = 1'b1;
            if ((bit_cnt_q != '0) && !word_done) short_d = 1'b1;
        end

        if (reg_rst) begin
            rx_sr_d      = '0;
            tx_sr_d      = '1;
            rx_dat_d     = '0;
            bit_cnt_d    = '0;
            word_cnt_d   = '0;
            short_d      = 1'b0;
            rx_vld_d     = 1'b0;
            tx_rd_en_d   = 1'b0;
            frame_done_d = 1'b0;
            tx_load_d    = 1'b0;
            start_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sr_q      <= '0;
            tx_sr_q      <= '1;
            rx_dat_q     <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            short_q      <= 1'b0;
            rx_vld_q     <= 1'b0;
            tx_rd_en_q   <= 1'b0;
            frame_done_q <= 1'b0;
            tx_load_q    <= 1'b0;
            start_pend_q <= 1'b0;
        end else begin
            rx_sr_q      <= rx_sr_d;
            tx_sr_q      <= tx_sr_d;
            rx_dat_q     <= rx_dat_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            short_q      <= short_d;
            rx_vld_q     <= rx_vld_d;
            tx_rd_en_q   <= tx_rd_en_d;
            frame_done_q <= frame_done_d;
            tx_load_q    <= tx_load_d;
            start_pend_q <= start_pend_d;
        end
    end

    assign miso        = (state_q == StShift && !full) ? tx_sr_q[WORD_W-1] : 1'b1;
    assign rx_vld      = rx_vld_q;
    assign rx_dat      = rx_dat_q;
    assign tx_rd_en    = tx_rd_en_q;
    assign frame_done  = frame_done_q;
    assign word_cnt    = word_cnt_q;
    assign short_frame = short_q;
    assign state       = state_q;

endmodule

// File: tb/tb_api_slave.sv
// Directed bench for api_slave: table of single-word frames plus hand-written
// sequences for latency, full/overlong/short frames, reset abort and load glitch.
`timescale 1ns/1ps
module tb_api_slave;

    localparam int W    = 32;
    localparam int SS   = 2;
    localparam int HALF = 6;

    logic          clk = 1'b0;
    logic          rst, reg_rst, load, sck, mosi;
    logic          miso, rx_vld, tx_rd_en, tx_empty, frame_done, short_frame;
    logic [W-1:0]  rx_dat, tx_dat, tx_word;
    logic [7:0]    word_cnt;
    logic [1:0]    state;

    api_slave #(.WORD_W(32), .FRAME_WORDS(23), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .reg_rst(reg_rst), .load(load), .sck(sck), .mosi(mosi),
        .miso(miso), .rx_vld(rx_vld), .rx_dat(rx_dat), .tx_rd_en(tx_rd_en),
        .tx_dat(tx_dat), .tx_empty(tx_empty), .frame_done(frame_done),
        .word_cnt(word_cnt), .short_frame(short_frame), .state(state)
    );

    always #5 clk = ~clk;

    // Non-FWFT source: word only valid in the cycle after the pop.
    always @(posedge clk) tx_dat <= tx_rd_en ? tx_word : 32'hDEAD_BEEF;

    int          rx_total = 0, fd_total = 0, rd_total = 0;
    logic [31:0] rx_log[$];
    logic [1:0]  done_state = 2'd3;

    always @(negedge clk) begin
        if (rx_vld) begin
            rx_total++;
            rx_log.push_back(rx_dat);
        end
        if (frame_done) begin
            fd_total++;
            done_state = state;
        end
        if (tx_rd_en) rd_total++;
    end

    int n_pass = 0, n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    endtask

    function automatic logic [31:0] rx_at(input int k);
        if (k < rx_log.size()) return rx_log[k];
        return 'x;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [31:0] mo, input int nbits, output logic [31:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[31-i];
            tick(HALF);
            mi  = {mi[30:0], miso};
            sck = 1'b1;
            tick(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic frame_begin();
        load = 1'b0;
        tick(10);
    endtask

    task automatic frame_end();
        tick(HALF);
        load = 1'b1;
        tick(10);
    endtask

    typedef struct {
        logic [31:0] mo;
        logic [31:0] tw;
        logic        te;
        logic [31:0] exp_miso;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] mi, mi0, mi23;
        logic        ones;
        int          rx0, fd0, rd0, idx;

        vecs[0] = '{mo: 32'h1234_5678, tw: 32'hA5A5_0F0F, te: 1'b0, exp_miso: 32'hA5A5_0F0F};
        vecs[1] = '{mo: 32'hFFFF_0000, tw: 32'h0000_FFFF, te: 1'b0, exp_miso: 32'h0000_FFFF};
        vecs[2] = '{mo: 32'h8000_0001, tw: 32'h7FFF_FFFE, te: 1'b0, exp_miso: 32'h7FFF_FFFE};
        vecs[3] = '{mo: 32'hDEAD_BEEF, tw: 32'h1357_9BDF, te: 1'b1, exp_miso: 32'hFFFF_FFFF};

        rst = 1'b1; reg_rst = 1'b0; load = 1'b1; sck = 1'b0; mosi = 1'b0;
        tx_word = '0; tx_empty = 1'b1;
        tick(3);
        check("reset_state", state, 2'd0);
        check("reset_miso", miso, 1'b1);
        check("reset_rx_vld", rx_vld, 1'b0);
        check("reset_rx_dat", rx_dat, 32'h0);
        check("reset_tx_rd_en", tx_rd_en, 1'b0);
        check("reset_frame_done", frame_done, 1'b0);
        check("reset_word_cnt", word_cnt, 8'd0);
        check("reset_short", short_frame, 1'b0);
        rst = 1'b0;
        tick(3);

        for (int v = 0; v < 4; v++) begin
            tx_word = vecs[v].tw; tx_empty = vecs[v].te;
            rx0 = rx_total; fd0 = fd_total; idx = rx_log.size();
            frame_begin();
            check($sformatf("v%0d_state_shift", v), state, 2'd1);
            shift_bits(vecs[v].mo, 32, mi);
            frame_end();
            check($sformatf("v%0d_rx_pulses", v), rx_total - rx0, 1);
            check($sformatf("v%0d_rx_dat", v), rx_at(idx), vecs[v].mo);
            check($sformatf("v%0d_miso", v), mi, vecs[v].exp_miso);
            check($sformatf("v%0d_word_cnt", v), word_cnt, 8'd1);
            check($sformatf("v%0d_frame_done", v), fd_total - fd0, 1);
            check($sformatf("v%0d_done_state", v), done_state, 2'd2);
        end

        // rx_vld appears SYNC_STAGES+2 cycles after the completing sck pin edge
        tx_empty = 1'b1;
        frame_begin();
        shift_bits(32'hC0FF_EE11, 31, mi);
        mosi = 1'b1;
        tick(HALF);
        sck = 1'b1;
        tick(SS + 1);
        check("latency_early", rx_vld, 1'b0);
        tick(1);
        check("latency_hit", rx_vld, 1'b1);
        check("latency_rx_dat", rx_dat, 32'hC0FF_EE11);
        tick(HALF - SS - 2);
        sck = 1'b0;
        frame_end();

        // full frame of 23 words, empty tx source
        tx_empty = 1'b1; ones = 1'b1;
        rx0 = rx_total; idx = rx_log.size();
        frame_begin();
        for (int i = 0; i < 23; i++) begin
            shift_bits(32'h1000_0000 + i, 32, mi);
            if (mi !== 32'hFFFF_FFFF) ones = 1'b0;
        end
        frame_end();
        check("full_rx_pulses", rx_total - rx0, 23);
        check("full_word_cnt", word_cnt, 8'd23);
        check("full_miso_ones", ones, 1'b1);
        check("full_last_word", rx_at(idx + 22), 32'h1000_0016);
        check("full_no_short", short_frame, 1'b0);

        // overlong frame of 25 words with a live tx source
        tx_empty = 1'b0; tx_word = 32'h5A5A_C3C3;
        rx0 = rx_total; fd0 = fd_total; rd0 = rd_total;
        mi0 = '0; mi23 = '0;
        frame_begin();
        for (int i = 0; i < 25; i++) begin
            shift_bits(32'h2000_0000 + i, 32, mi);
            if (i == 0) mi0 = mi;
            if (i == 23) mi23 = mi;
        end
        frame_end();
        check("over_rx_pulses", rx_total - rx0, 23);
        check("over_word_cnt", word_cnt, 8'd23);
        check("over_miso_first", mi0, 32'h5A5A_C3C3);
        check("over_miso_beyond", mi23, 32'hFFFF_FFFF);
        check("over_tx_pops", rd_total - rd0, 23);
        check("over_frame_done", fd_total - fd0, 1);

        // short frame: 2 words + 7 bits
        tx_empty = 1'b1;
        rx0 = rx_total; fd0 = fd_total;
        frame_begin();
        shift_bits(32'h3333_0001, 32, mi);
        shift_bits(32'h3333_0002, 32, mi);
        shift_bits(32'hFE00_0000, 7, mi);
        frame_end();
        check("short_rx_pulses", rx_total - rx0, 2);
        check("short_flag", short_frame, 1'b1);
        check("short_frame_done", fd_total - fd0, 1);
        check("short_word_cnt", word_cnt, 8'd2);
        frame_begin();
        shift_bits(32'h4444_0001, 32, mi);
        frame_end();
        check("short_sticky", short_frame, 1'b1);
        reg_rst = 1'b1;
        tick(1);
        reg_rst = 1'b0;
        check("soft_rst_short", short_frame, 1'b0);
        check("soft_rst_word_cnt", word_cnt, 8'd0);

        // asynchronous reset mid-word aborts the frame silently
        frame_begin();
        shift_bits(32'h5555_5555, 10, mi);
        fd0 = fd_total;
        #2;
        rst = 1'b1; load = 1'b1; sck = 1'b0;
        #1;
        check("arst_state", state, 2'd0);
        check("arst_miso", miso, 1'b1);
        check("arst_rx_dat", rx_dat, 32'h0);
        check("arst_word_cnt", word_cnt, 8'd0);
        tick(2);
        rst = 1'b0;
        tick(10);
        check("arst_no_frame_done", fd_total - fd0, 0);
        idx = rx_log.size();
        frame_begin();
        shift_bits(32'h6789_ABCD, 32, mi);
        frame_end();
        check("arst_new_rx", rx_at(idx), 32'h6789_ABCD);
        check("arst_new_word_cnt", word_cnt, 8'd1);
        check("arst_new_frame_done", fd_total - fd0, 1);

        // back-to-back frames separated by a SYNC_STAGES+1 cycle load glitch
        rx0 = rx_total; fd0 = fd_total; idx = rx_log.size();
        frame_begin();
        shift_bits(32'h0BAD_F00D, 32, mi);
        tick(HALF);
        load = 1'b1;
        tick(SS + 1);
        load = 1'b0;
        tick(10);
        shift_bits(32'hFACE_0FF1, 32, mi);
        frame_end();
        check("glitch_frame_done", fd_total - fd0, 2);
        check("glitch_rx_pulses", rx_total - rx0, 2);
        check("glitch_second_word", rx_at(idx + 1), 32'hFACE_0FF1);
        check("glitch_word_cnt", word_cnt, 8'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
